// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: two-master front end for a single-port register file.
// Each master posts one request at a time; a four-state FSM serialises them
// onto the register-file strobes and returns a one-cycle completion pulse.
module rf_access_arbiter #(
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              res,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read_en,
   input  logic              m0_write_en,
   input  logic [DATA_W-1:0] m0_write_data,
   output logic [DATA_W-1:0] m0_read_data,
   output logic              m0_access_complete,
   output logic              m0_invalid_address,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read_en,
   input  logic              m1_write_en,
   input  logic [DATA_W-1:0] m1_write_data,
   output logic [DATA_W-1:0] m1_read_data,
   output logic              m1_access_complete,
   output logic              m1_invalid_address,
   output logic [ADDR_W-1:0] rf_address,
   output logic              rf_read_en,
   output logic              rf_write_en,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [DATA_W-1:0] rf_read_data,
   input  logic              rf_access_complete,
   input  logic              rf_invalid_address,
   output logic [7:0]        timeout_count
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ILLEGAL} op_t;

   // Last WAIT cycle index; the counter starts at 0 on the first WAIT cycle.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   function automatic op_t decode_op(input logic rd, input logic wr);
      if (rd && wr)
         return OP_ILLEGAL;
      else if (wr)
         return OP_WRITE;
      else
         return OP_READ;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [1:0]        req_rd;
   logic [1:0]        req_wr;
   logic [1:0]        req_pulse;
   logic [ADDR_W-1:0] req_addr  [2];
   logic [DATA_W-1:0] req_wdata [2];

   logic [1:0]        pending;
   op_t               hold_op    [2];
   logic [ADDR_W-1:0] hold_addr  [2];
   logic [DATA_W-1:0] hold_wdata [2];

   state_t            state;
   state_t            next_state;
   logic              grant;
   logic              grant_next;
   logic              last_grant;
   logic              tie;
   logic [7:0]        wait_cnt;
   logic [1:0]        clr;
   op_t               cur_op;

   logic [DATA_W-1:0] resp_data_next;
   logic              resp_inv_next;
   logic              timeout_hit;

   logic [1:0]        cpl_q;
   logic [1:0]        inv_q;
   logic [DATA_W-1:0] rdata_q [2];

   assign req_rd       = {m1_read_en, m0_read_en};
   assign req_wr       = {m1_write_en, m0_write_en};
   assign req_pulse    = req_rd | req_wr;
   assign req_addr[0]  = m0_address;
   assign req_addr[1]  = m1_address;
   assign req_wdata[0] = m0_write_data;
   assign req_wdata[1] = m1_write_data;

   // The granted master's pending flag drops in the RESP cycle.
   assign clr    = (state == S_RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign cur_op = hold_op[grant];

   // Request capture; a new pulse on the clearing cycle wins over the clear.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         pending <= '0;
         for (int i = 0; i < 2; i++) begin
            hold_op[i]    <= OP_READ;
            hold_addr[i]  <= '0;
            hold_wdata[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (req_pulse[i] && (!pending[i] || clr[i])) begin
               pending[i]    <= 1'b1;
               hold_op[i]    <= decode_op(req_rd[i], req_wr[i]);
               hold_addr[i]  <= req_addr[i];
               hold_wdata[i] <= req_wdata[i];
            end else if (clr[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // Next-state, grant selection, register-file strobes and response data.
   always_comb begin
      next_state     = state;
      grant_next     = grant;
      tie            = 1'b0;
      resp_data_next = '0;
      resp_inv_next  = 1'b0;
      timeout_hit    = 1'b0;
      rf_address     = '0;
      rf_write_data  = '0;
      rf_read_en     = 1'b0;
      rf_write_en    = 1'b0;
      case (state)
         S_IDLE: begin
            if (pending != 2'b00) begin
               next_state = S_ISSUE;
               if (pending == 2'b11) begin
                  tie        = 1'b1;
                  grant_next = ~last_grant;
               end else begin
                  grant_next = pending[1];
               end
            end
         end
         S_ISSUE: begin
            if (cur_op == OP_ILLEGAL) begin
               next_state    = S_RESP;
               resp_inv_next = 1'b1;
            end else begin
               next_state    = S_WAIT;
               rf_address    = hold_addr[grant];
               rf_write_data = hold_wdata[grant];
               rf_read_en    = (cur_op == OP_READ);
               rf_write_en   = (cur_op == OP_WRITE);
            end
         end
         S_WAIT: begin
            if (rf_access_complete) begin
               next_state     = S_RESP;
               resp_data_next = (cur_op == OP_READ) ? rf_read_data : '0;
               resp_inv_next  = rf_invalid_address;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state    = S_RESP;
               resp_inv_next = 1'b1;
               timeout_hit   = 1'b1;
            end
         end
         S_RESP: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // FSM state, grant, tie-break history, wait counter and timeout tally.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state         <= S_IDLE;
         grant         <= 1'b0;
         last_grant    <= 1'b1;
         wait_cnt      <= '0;
         timeout_count <= '0;
      end else begin
         state <= next_state;
         grant <= grant_next;
         if (tie)
            last_grant <= grant_next;
         if (state == S_ISSUE)
            wait_cnt <= '0;
         else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 8'd1;
         if (timeout_hit)
            timeout_count <= sat_inc8(timeout_count);
      end
   end

   // Registered per-master response: only the granted master sees non-zero.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cpl_q <= '0;
         inv_q <= '0;
         for (int i = 0; i < 2; i++)
            rdata_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if ((next_state == S_RESP) && (grant == 1'(i))) begin
               cpl_q[i]   <= 1'b1;
               inv_q[i]   <= resp_inv_next;
               rdata_q[i] <= resp_data_next;
            end else begin
               cpl_q[i]   <= 1'b0;
               inv_q[i]   <= 1'b0;
               rdata_q[i] <= '0;
            end
         end
      end
   end

   assign m0_access_complete = cpl_q[0];
   assign m0_invalid_address = inv_q[0];
   assign m0_read_data       = rdata_q[0];
   assign m1_access_complete = cpl_q[1];
   assign m1_invalid_address = inv_q[1];
   assign m1_read_data       = rdata_q[1];

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Self-checking bench for rf_access_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_rf_access_arbiter;

   localparam int ADDR_W  = 2;
   localparam int DATA_W  = 64;
   localparam int TIMEOUT = 15;
   localparam int OP_R    = 0;
   localparam int OP_W    = 1;
   localparam int OP_I    = 2;

   logic              clk = 1'b0;
   logic              res = 1'b1;
   logic [ADDR_W-1:0] m0_address = '0;
   logic              m0_read_en = 1'b0;
   logic              m0_write_en = 1'b0;
   logic [DATA_W-1:0] m0_write_data = '0;
   logic [DATA_W-1:0] m0_read_data;
   logic              m0_access_complete;
   logic              m0_invalid_address;
   logic [ADDR_W-1:0] m1_address = '0;
   logic              m1_read_en = 1'b0;
   logic              m1_write_en = 1'b0;
   logic [DATA_W-1:0] m1_write_data = '0;
   logic [DATA_W-1:0] m1_read_data;
   logic              m1_access_complete;
   logic              m1_invalid_address;
   logic [ADDR_W-1:0] rf_address;
   logic              rf_read_en;
   logic              rf_write_en;
   logic [DATA_W-1:0] rf_write_data;
   logic [DATA_W-1:0] rf_read_data = '0;
   logic              rf_access_complete = 1'b0;
   logic              rf_invalid_address = 1'b0;
   logic [7:0]        timeout_count;

   int checks = 0;
   int errors = 0;

   // Reference model: outstanding request per master, tie-break history,
   // expected timeout tally.
   bit                pend   [2];
   int                p_op   [2];
   logic [ADDR_W-1:0] p_addr [2];
   logic [DATA_W-1:0] p_wd   [2];
   int                last;
   int                tcount;

   rf_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .res(res),
      .m0_address(m0_address), .m0_read_en(m0_read_en), .m0_write_en(m0_write_en),
      .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
      .m0_access_complete(m0_access_complete), .m0_invalid_address(m0_invalid_address),
      .m1_address(m1_address), .m1_read_en(m1_read_en), .m1_write_en(m1_write_en),
      .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
      .m1_access_complete(m1_access_complete), .m1_invalid_address(m1_invalid_address),
      .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
      .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
      .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address),
      .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input int x, input int op, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd);
      logic rd;
      logic wr;
      rd = (op == OP_R) || (op == OP_I);
      wr = (op == OP_W) || (op == OP_I);
      if (x == 0) begin
         m0_read_en = rd; m0_write_en = wr; m0_address = a; m0_write_data = wd;
      end else begin
         m1_read_en = rd; m1_write_en = wr; m1_address = a; m1_write_data = wd;
      end
   endtask

   task automatic clear_reqs();
      m0_read_en = 1'b0; m0_write_en = 1'b0;
      m1_read_en = 1'b0; m1_write_en = 1'b0;
   endtask

   // Pulse a request and let the model accept it only if nothing is outstanding.
   task automatic request(input int x, input int op, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
      drive_req(x, op, a, wd);
      if (!pend[x]) begin
         pend[x] = 1'b1; p_op[x] = op; p_addr[x] = a; p_wd[x] = wd;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rf_rd"}, rf_read_en, 0);
      chk({tag, "_rf_wr"}, rf_write_en, 0);
      chk({tag, "_rf_addr"}, rf_address, 0);
      chk({tag, "_rf_wdata"}, rf_write_data, 0);
      chk({tag, "_cpl"}, {m1_access_complete, m0_access_complete}, 0);
      chk({tag, "_m0_rdata"}, m0_read_data, 0);
      chk({tag, "_m1_rdata"}, m1_read_data, 0);
      chk({tag, "_inv"}, {m1_invalid_address, m0_invalid_address}, 0);
      chk({tag, "_tcount"}, timeout_count, 0);
   endtask

   // One service from its IDLE cycle (k=0) to its RESP cycle. d is the WAIT
   // cycle on which the register file completes; negative means never.
   task automatic serve(input int m, input int op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input int d, input logic rinv,
                        input logic [DATA_W-1:0] rdata, input bit junk);
      int          resp_k;
      logic [63:0] exp_rd;
      logic        exp_inv;
      bit          completes;
      completes = (op != OP_I) && (d >= 0) && (d < TIMEOUT);
      if (op == OP_I) begin
         resp_k = 2; exp_rd = '0; exp_inv = 1'b1;
      end else if (completes) begin
         resp_k = 3 + d; exp_rd = (op == OP_R) ? rdata : '0; exp_inv = rinv;
      end else begin
         resp_k = 2 + TIMEOUT; exp_rd = '0; exp_inv = 1'b1;
         if (tcount < 255) tcount++;
      end
      for (int k = 0; k <= resp_k; k++) begin
         @(negedge clk);
         if (k == 0) begin
            clear_reqs();
            if (junk) drive_req(m, OP_W, ~a, ~wd);
         end
         if (k == 1) clear_reqs();
         chk("rf_read_en", rf_read_en, (k == 1) && (op == OP_R));
         chk("rf_write_en", rf_write_en, (k == 1) && (op == OP_W));
         if (k == 1 && op != OP_I) chk("rf_address", rf_address, a);
         if (k == 1 && op == OP_W) chk("rf_write_data", rf_write_data, wd);
         chk("complete_vec", {m1_access_complete, m0_access_complete},
             (k == resp_k) ? ((m == 0) ? 2'b01 : 2'b10) : 2'b00);
         if (k == resp_k) begin
            chk("read_data", (m == 0) ? m0_read_data : m1_read_data, exp_rd);
            chk("invalid", (m == 0) ? m0_invalid_address : m1_invalid_address, exp_inv);
         end
         chk("other_rdata", (m == 0) ? m1_read_data : m0_read_data, 0);
         chk("other_invalid", (m == 0) ? m1_invalid_address : m0_invalid_address, 0);
         rf_access_complete = 1'b0;
         rf_read_data       = {$urandom, $urandom};
         rf_invalid_address = 1'($urandom % 2);
         if (completes && k == 2 + d) begin
            rf_access_complete = 1'b1;
            rf_read_data       = rdata;
            rf_invalid_address = rinv;
         end else if (k <= 1 && ($urandom % 4) == 0) begin
            rf_access_complete = 1'b1;
         end
      end
      chk("timeout_count", timeout_count, tcount);
   endtask

   task automatic serve_as(input int m, input int d, input logic rinv,
                           input logic [DATA_W-1:0] rdata, input bit junk);
      if (pend[0] && pend[1]) last = m;
      serve(m, p_op[m], p_addr[m], p_wd[m], d, rinv, rdata, junk);
      pend[m] = 1'b0;
   endtask

   function automatic int pick_delay();
      int r;
      r = int'($urandom % 16);
      if (r < 10)       return r % 4;
      else if (r < 13)  return int'($urandom % TIMEOUT);
      else if (r == 13) return TIMEOUT - 1;
      else if (r == 14) return -1;
      else              return 0;
   endfunction

   task automatic serve_next();
      int g;
      if (pend[0] && pend[1]) g = 1 - last;
      else                    g = pend[1] ? 1 : 0;
      serve_as(g, pick_delay(), 1'($urandom % 4 == 0), {$urandom, $urandom},
               ($urandom % 4) == 0);
   endtask

   initial begin
      int                rop;
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rwd;
      pend[0] = 1'b0; pend[1] = 1'b0;
      last = 1; tcount = 0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");

      // First edge after release takes the write.
      res = 1'b0;
      request(0, OP_W, 2'd2, 64'h555AAA555AAA555A);
      serve_as(0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0);

      // Simultaneous reads: m0 wins first tie, m1 wins the next one.
      request(0, OP_R, 2'd1, '0);
      request(1, OP_R, 2'd3, '0);
      serve_as(0, 1, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
      serve_as(1, 0, 1'b1, 64'h5555_6666_7777_8888, 1'b0);
      request(0, OP_R, 2'd2, '0);
      request(1, OP_R, 2'd0, '0);
      serve_as(1, 2, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
      serve_as(0, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);

      request(1, OP_R, 2'd0, '0);
      serve_as(1, 0, 1'b0, 64'h12ABCD, 1'b0);

      // Register file never answers.
      request(0, OP_R, 2'd3, '0);
      serve_as(0, -1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

      // Illegal op, plus a second pulse while it is still outstanding.
      request(0, OP_I, 2'd1, 64'h42);
      serve_as(0, 0, 1'b0, 64'h99, 1'b1);

      for (int r = 0; r < 100; r++) begin
         for (int x = 0; x < 2; x++) begin
            if (($urandom % 2) == 1) begin
               rop = (($urandom % 8) == 0) ? OP_I : int'($urandom % 2);
               ra  = ADDR_W'($urandom);
               rwd = {$urandom, $urandom};
               request(x, rop, ra, rwd);
            end
         end
         if (!pend[0] && !pend[1]) begin
            rop = (($urandom % 8) == 0) ? OP_I : int'($urandom % 2);
            ra  = ADDR_W'($urandom);
            rwd = {$urandom, $urandom};
            request(int'($urandom % 2), rop, ra, rwd);
         end
         serve_next();
      end
      for (int i = 0; i < 2; i++)
         if (pend[0] || pend[1]) serve_next();

      // Reset in the middle of WAIT with another request queued.
      request(0, OP_R, 2'd1, '0);
      request(1, OP_R, 2'd2, '0);
      @(negedge clk);
      clear_reqs();
      rf_access_complete = 1'b0;
      @(negedge clk);
      chk("issue_before_reset", rf_read_en, 1);
      @(negedge clk);
      @(negedge clk);
      res = 1'b1;
      #1;
      check_all_zero("async_reset");
      pend[0] = 1'b0; pend[1] = 1'b0;
      last = 1; tcount = 0;
      @(negedge clk);
      @(negedge clk);
      res = 1'b0;
      rf_access_complete = 1'b1;
      rf_read_data       = 64'hBAD0_BAD0_BAD0_BAD0;
      rf_invalid_address = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         rf_access_complete = 1'b0;
         chk("post_reset_cpl", {m1_access_complete, m0_access_complete}, 0);
         chk("post_reset_strobe", {rf_read_en, rf_write_en}, 0);
      end

      // Tie-break history is back to its reset value.
      request(0, OP_R, 2'd1, '0);
      request(1, OP_W, 2'd2, 64'hCAFE_F00D_CAFE_F00D);
      serve_as(0, 0, 1'b0, 64'h7777_0000_7777_0000, 1'b0);
      serve_as(1, 1, 1'b0, 64'h1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
